// File: rtl/codif_pkg.sv
// Shared constants and types for the Gray-code encoder/decoder pair.
package codif_pkg;

    // Width of a code word / decoded nibble.
    localparam int CODE_W = 4;

    // Bit index loaded at capture; the decode walks from here down to 0.
    localparam logic [1:0] IDX_MSB = 2'd3;

    // Decoder FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } state_t;

endpackage

// File: rtl/decodificador_gray_bit_step.sv
// One stage of the Gray decode recurrence: next bit = previous bit ^ code bit.
module gray_bit_step (
    input  logic prev_i,
    input  logic code_bit_i,
    output logic next_o
);

    assign next_o = prev_i ^ code_bit_i;

endmodule

// File: rtl/decodificador.sv
// Serial Gray-code decoder: captures S3..S0 on ready, recovers A..D one bit
// per clock MSB first, then publishes the nibble with a one-cycle valid pulse.
module decodificador
    import codif_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic S3,
    input  logic S2,
    input  logic S1,
    input  logic S0,
    input  logic ready,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic valid,
    output logic busy,
    output logic ovr
);

    state_t              state_q;
    logic [CODE_W-1:0]   shreg_q;
    logic [CODE_W-1:0]   stage_q;
    logic [CODE_W-1:0]   stage_d;
    logic [CODE_W-1:0]   abcd_q;
    logic [1:0]          idx_q;
    logic                run_q;
    logic                next_bit;
    logic                valid_q;
    logic                busy_q;
    logic                ovr_q;

    // The bit being decoded this cycle comes from the running bit and the
    // code bit currently at the top of the shift register.
    gray_bit_step u_step (
        .prev_i     (run_q),
        .code_bit_i (shreg_q[CODE_W-1]),
        .next_o     (next_bit)
    );

    // Staging word with this cycle's bit merged in, so the last step can
    // publish the complete nibble on the same edge it is computed.
    always_comb begin
        stage_d        = stage_q;
        stage_d[idx_q] = next_bit;
    end

    // Decoder FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            stage_q <= '0;
            abcd_q  <= '0;
            idx_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ready) begin
                        shreg_q <= {S3, S2, S1, S0};
                        run_q   <= 1'b0;
                        idx_q   <= IDX_MSB;
                        state_q <= ST_STEP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_STEP: begin
                    // A strobe arriving mid-decode is dropped and flagged.
                    ovr_q   <= ready;
                    run_q   <= next_bit;
                    stage_q <= stage_d;
                    shreg_q <= {shreg_q[CODE_W-2:0], 1'b0};
                    idx_q   <= idx_q - 2'd1;
                    if (idx_q == 2'd0) begin
                        abcd_q  <= stage_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A     = abcd_q[3];
    assign B     = abcd_q[2];
    assign C     = abcd_q[1];
    assign D     = abcd_q[0];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_decodificador.sv
// Self-checking bench for the serial Gray-code decoder.
module tb_decodificador;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ready = 1'b0;
    logic [3:0] s = 4'b0000;
    logic       A, B, C, D, valid, busy, ovr;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int ovr_cnt = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int         m_cnt = 0;
    logic [3:0] m_word = '0;
    logic [3:0] m_abcd = '0;
    logic       m_valid = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_ovr = 1'b0;

    always #5 clk = ~clk;

    decodificador dut (
        .clk   (clk),
        .reset (reset),
        .S3    (s[3]),
        .S2    (s[2]),
        .S1    (s[1]),
        .S0    (s[0]),
        .ready (ready),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .valid (valid),
        .busy  (busy),
        .ovr   (ovr)
    );

    function automatic logic [3:0] enc(input logic [3:0] n);
        return {n[3], n[3] ^ n[2], n[2] ^ n[1], n[1] ^ n[0]};
    endfunction

    // Decode by searching for the nibble whose encoding matches the word.
    function automatic logic [3:0] dec(input logic [3:0] w);
        logic [3:0] r;
        r = '0;
        for (int n = 0; n < 16; n++)
            if (enc(4'(n)) == w) r = 4'(n);
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: idle until a strobe, then count four step cycles.
    always @(posedge clk) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        if (reset) begin
            m_cnt  = 0;
            m_abcd = '0;
            m_busy = 1'b0;
        end else if (m_cnt == 0) begin
            if (ready) begin
                m_word = s;
                m_cnt  = 4;
                m_busy = 1'b1;
            end
        end else begin
            if (ready) m_ovr = 1'b1;
            m_cnt--;
            if (m_cnt == 0) begin
                m_abcd  = dec(m_word);
                m_valid = 1'b1;
                m_busy  = 1'b0;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("abcd",  {A, B, C, D}, m_abcd);
            chk("valid", {3'b0, valid}, {3'b0, m_valid});
            chk("busy",  {3'b0, busy},  {3'b0, m_busy});
            chk("ovr",   {3'b0, ovr},   {3'b0, m_ovr});
            if (valid) valid_cnt++;
            if (ovr) ovr_cnt++;
        end
    end

    initial begin
        int v0, o0;

        // Pin the model against hand-computed values.
        chk("pin_dec_0111", dec(4'b0111), 4'b0101);
        chk("pin_dec_1000", dec(4'b1000), 4'b1111);
        chk("pin_dec_1111", dec(4'b1111), 4'b1010);
        chk("pin_enc_0101", enc(4'b0101), 4'b0111);

        // Reset for two cycles, then idle.
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_abcd", {A, B, C, D}, 4'b0000);
        chk("rst_flags", {1'b0, valid, busy, ovr}, 4'b0000);
        repeat (10) tick();
        chk("idle_valid_cnt", 4'(valid_cnt), 4'd0);

        // Single decode of 0111.
        s = 4'b0111; ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("cap_busy", {3'b0, busy}, 4'b0001);
        repeat (3) tick();
        chk("pre_valid", {3'b0, valid}, 4'b0000);
        tick();
        chk("single_abcd", {A, B, C, D}, 4'b0101);
        chk("single_valid", {2'b0, valid, busy}, 4'b0010);
        tick();
        chk("single_valid_drop", {3'b0, valid}, 4'b0000);

        // Sweep all nibbles, strobing every 5 cycles.
        for (int n = 0; n < 16; n++) begin
            s = enc(4'(n)); ready = 1'b1;
            tick();
            ready = 1'b0;
            repeat (4) tick();
            chk("sweep", {A, B, C, D}, 4'(n));
        end
        tick();

        // Overlapping strobe is dropped.
        v0 = valid_cnt; o0 = ovr_cnt;
        s = 4'b0111; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        s = 4'b1000; ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("ovr_pulse", {3'b0, ovr}, 4'b0001);
        repeat (2) tick();
        chk("ovr_abcd", {A, B, C, D}, 4'b0101);
        repeat (6) tick();
        chk("ovr_valid_cnt", 4'(valid_cnt - v0), 4'd1);
        chk("ovr_cnt", 4'(ovr_cnt - o0), 4'd1);

        // Reset aborts an in-flight decode.
        v0 = valid_cnt;
        s = 4'b1111; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_abcd", {A, B, C, D}, 4'b0000);
        chk("abort_flags", {1'b0, valid, busy, ovr}, 4'b0000);
        repeat (5) tick();
        chk("abort_no_valid", 4'(valid_cnt - v0), 4'd0);
        s = 4'b1000; ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (4) tick();
        chk("post_abort_abcd", {A, B, C, D}, 4'b1111);
        tick();

        // Reset and ready on the same edge: nothing captured.
        reset = 1'b1; ready = 1'b1; s = 4'b0111;
        tick();
        reset = 1'b0; ready = 1'b0;
        chk("rst_ready_busy", {3'b0, busy}, 4'b0000);
        tick();

        // Ready held high continuously.
        v0 = valid_cnt; o0 = ovr_cnt;
        s = 4'b1111; ready = 1'b1;
        repeat (20) tick();
        chk("cont_abcd", {A, B, C, D}, 4'b1010);
        ready = 1'b0;
        tick();
        chk("cont_valid_cnt", 5'(valid_cnt - v0) == 5'd4 ? 4'd4 : 4'(valid_cnt - v0), 4'd4);
        chk("cont_ovr_cnt", 5'(ovr_cnt - o0) == 5'd16 ? 4'hF : 4'(ovr_cnt - o0), 4'hF);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
